// File: rtl/wd_channel_scheduler.sv
// Write-data channel scheduler: routes per-master W beats to one slave W channel
// in AW grant order, using a FIFO of granted master IDs and an IDLE/ACTIVE FSM.
module wd_channel_scheduler #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int MID_W      = $clog2(NUM_MASTERS),
    localparam int STRB_W     = DATA_WIDTH / 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            AW_Grant_Valid,
    input  logic [MID_W-1:0]                AW_Grant_Id,
    output logic                            Queue_Full,
    output logic                            Overflow,
    input  logic [NUM_MASTERS-1:0]          S_WVALID,
    input  logic [NUM_MASTERS-1:0]          S_WLAST,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] S_WDATA,
    input  logic [NUM_MASTERS*STRB_W-1:0]   S_WSTRB,
    output logic [NUM_MASTERS-1:0]          S_WREADY,
    output logic                            M_WVALID,
    output logic                            M_WLAST,
    output logic [DATA_WIDTH-1:0]           M_WDATA,
    output logic [STRB_W-1:0]               M_WSTRB,
    input  logic                            M_WREADY,
    output logic                            Active,
    output logic [MID_W-1:0]                Active_Id,
    output logic [7:0]                      Beat_Count,
    output logic                            Burst_Done,
    output logic [MID_W-1:0]                Burst_Done_Id
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t             state_r;
    logic               active_r;
    logic [MID_W-1:0]   active_id_r;
    logic [7:0]         beat_cnt_r;
    logic               done_r;
    logic [MID_W-1:0]   done_id_r;

    logic [MID_W-1:0]   q_mem_r [QUEUE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_next_s;
    logic               full_r;
    logic               overflow_r;

    logic               empty_s;
    logic               hs_s;
    logic               last_hs_s;
    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic [MID_W-1:0]   head_s;

    logic                   m_wvalid_s;
    logic                   m_wlast_s;
    logic [DATA_WIDTH-1:0]  m_wdata_s;
    logic [STRB_W-1:0]      m_wstrb_s;
    logic [NUM_MASTERS-1:0] s_wready_s;

    // Owner routing: only the registered owner's slice reaches the slave side
    always_comb begin
        m_wvalid_s = 1'b0;
        m_wlast_s  = 1'b0;
        m_wdata_s  = {DATA_WIDTH{1'b0}};
        m_wstrb_s  = {STRB_W{1'b0}};
        s_wready_s = {NUM_MASTERS{1'b0}};
        if ((state_r == ST_ACTIVE) && (int'(active_id_r) < NUM_MASTERS)) begin
            m_wvalid_s              = S_WVALID[active_id_r];
            m_wlast_s               = S_WLAST[active_id_r];
            m_wdata_s               = S_WDATA[active_id_r*DATA_WIDTH +: DATA_WIDTH];
            m_wstrb_s               = S_WSTRB[active_id_r*STRB_W +: STRB_W];
            s_wready_s[active_id_r] = M_WREADY;
        end else begin
            m_wvalid_s = 1'b0;
            s_wready_s = {NUM_MASTERS{1'b0}};
        end
    end

    // Queue control: a pop happens whenever the FSM loads a new owner
    always_comb begin
        empty_s   = (count_r == {CNT_W{1'b0}});
        head_s    = q_mem_r[rd_ptr_r];
        hs_s      = (state_r == ST_ACTIVE) && m_wvalid_s && M_WREADY;
        last_hs_s = hs_s && m_wlast_s;
        pop_s     = !empty_s && ((state_r == ST_IDLE) || last_hs_s);
        push_s    = AW_Grant_Valid && (!full_r || pop_s);
        drop_s    = AW_Grant_Valid && full_r && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE_C;
            2'b01:   count_next_s = count_r - CNT_ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // ID storage; contents are qualified by the pointers, so no reset needed
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            q_mem_r[wr_ptr_r] <= AW_Grant_Id;
        end
    end

    // Queue pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
        end
    end

    // Burst FSM; a load on the WLAST handshake chains bursts with no bubble
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r     <= ST_IDLE;
            active_r    <= 1'b0;
            active_id_r <= {MID_W{1'b0}};
            beat_cnt_r  <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r     <= ST_ACTIVE;
                        active_r    <= 1'b1;
                        active_id_r <= head_s;
                        beat_cnt_r  <= 8'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (hs_s && (beat_cnt_r != 8'hFF)) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                    end
                    if (last_hs_s) begin
                        if (pop_s) begin
                            active_id_r <= head_s;
                            beat_cnt_r  <= 8'd0;
                        end else begin
                            state_r  <= ST_IDLE;
                            active_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    active_r <= 1'b0;
                end
            endcase
        end
    end

    // Completion pulse, one cycle after the WLAST handshake
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            done_r    <= 1'b0;
            done_id_r <= {MID_W{1'b0}};
        end else begin
            done_r <= last_hs_s;
            if (last_hs_s) begin
                done_id_r <= active_id_r;
            end
        end
    end

    assign Queue_Full    = full_r;
    assign Overflow      = overflow_r;
    assign Active        = active_r;
    assign Active_Id     = active_id_r;
    assign Beat_Count    = beat_cnt_r;
    assign Burst_Done    = done_r;
    assign Burst_Done_Id = done_id_r;
    assign M_WVALID      = m_wvalid_s;
    assign M_WLAST       = m_wlast_s;
    assign M_WDATA       = m_wdata_s;
    assign M_WSTRB       = m_wstrb_s;
    assign S_WREADY      = s_wready_s;

endmodule

// File: tb/tb_wd_channel_scheduler.sv
// Directed bench for wd_channel_scheduler: latency, ordering, backpressure,
// queue full/overflow and mid-burst reset, with hand-computed expectations.
module tb_wd_channel_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AW_Grant_Valid;
    logic [0:0]  AW_Grant_Id;
    logic        Queue_Full;
    logic        Overflow;
    logic [1:0]  S_WVALID;
    logic [1:0]  S_WLAST;
    logic [63:0] S_WDATA;
    logic [7:0]  S_WSTRB;
    logic [1:0]  S_WREADY;
    logic        M_WVALID;
    logic        M_WLAST;
    logic [31:0] M_WDATA;
    logic [3:0]  M_WSTRB;
    logic        M_WREADY;
    logic        Active;
    logic [0:0]  Active_Id;
    logic [7:0]  Beat_Count;
    logic        Burst_Done;
    logic [0:0]  Burst_Done_Id;

    int total = 0;
    int bad   = 0;
    int hs    = 0;

    wd_channel_scheduler #(
        .NUM_MASTERS (2),
        .DATA_WIDTH  (32),
        .QUEUE_DEPTH (4)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .AW_Grant_Valid (AW_Grant_Valid),
        .AW_Grant_Id    (AW_Grant_Id),
        .Queue_Full     (Queue_Full),
        .Overflow       (Overflow),
        .S_WVALID       (S_WVALID),
        .S_WLAST        (S_WLAST),
        .S_WDATA        (S_WDATA),
        .S_WSTRB        (S_WSTRB),
        .S_WREADY       (S_WREADY),
        .M_WVALID       (M_WVALID),
        .M_WLAST        (M_WLAST),
        .M_WDATA        (M_WDATA),
        .M_WSTRB        (M_WSTRB),
        .M_WREADY       (M_WREADY),
        .Active         (Active),
        .Active_Id      (Active_Id),
        .Beat_Count     (Beat_Count),
        .Burst_Done     (Burst_Done),
        .Burst_Done_Id  (Burst_Done_Id)
    );

    initial forever #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic drv(input logic [1:0] v, input logic [1:0] l,
                       input logic [31:0] d0, input logic [31:0] d1);
        S_WVALID = v;
        S_WLAST  = l;
        S_WDATA  = {d1, d0};
    endtask

    task automatic route(input string tag, input logic [0:0] id,
                         input logic [31:0] d, input logic last);
        chk({tag, "_active"}, Active, 1'b1);
        chk({tag, "_id"}, Active_Id, id);
        chk({tag, "_mvalid"}, M_WVALID, 1'b1);
        chk({tag, "_mdata"}, M_WDATA, d);
        chk({tag, "_mlast"}, M_WLAST, last);
        chk({tag, "_sready"}, S_WREADY, (id == 1'b1) ? 2'b10 : 2'b01);
    endtask

    initial begin
        ARESET = 1'b1; AW_Grant_Valid = 1'b0; AW_Grant_Id = 1'b0;
        S_WVALID = 2'b00; S_WLAST = 2'b00; S_WDATA = 64'd0;
        S_WSTRB = {4'h3, 4'hF}; M_WREADY = 1'b0;
        tick(); tick();
        ARESET = 1'b0; #1;
        chk("rst_active", Active, 1'b0);
        chk("rst_full", Queue_Full, 1'b0);
        chk("rst_ovf", Overflow, 1'b0);
        chk("rst_beat", Beat_Count, 8'd0);
        chk("rst_done", Burst_Done, 1'b0);
        chk("rst_mvalid", M_WVALID, 1'b0);
        chk("rst_sready", S_WREADY, 2'b00);

        // single burst from master 1, grant at cycle N
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b1; M_WREADY = 1'b1;
        drv(2'b10, 2'b00, 32'h0, 32'hA000_0000); #1;
        chk("lat_n_active", Active, 1'b0);
        chk("lat_n_mvalid", M_WVALID, 1'b0);
        chk("lat_n_sready", S_WREADY, 2'b00);
        tick();
        AW_Grant_Valid = 1'b0; #1;
        chk("lat_n1_active", Active, 1'b0);
        chk("lat_n1_mvalid", M_WVALID, 1'b0);
        tick();
        for (int b = 0; b < 4; b++) begin
            drv(2'b10, {(b == 3), 1'b0}, 32'h0, 32'hA000_0000 + 32'(b)); #1;
            route("single", 1'b1, 32'hA000_0000 + 32'(b), (b == 3));
            chk("single_strb", M_WSTRB, 4'h3);
            chk("single_beat", Beat_Count, 8'(b));
            tick();
        end
        drv(2'b00, 2'b00, 32'h0, 32'h0); #1;
        chk("single_done", Burst_Done, 1'b1);
        chk("single_done_id", Burst_Done_Id, 1'b1);
        chk("single_idle", Active, 1'b0);
        chk("single_beat_end", Beat_Count, 8'd4);
        chk("single_idle_mvalid", M_WVALID, 1'b0);
        tick(); #1;
        chk("single_done_pulse", Burst_Done, 1'b0);

        // ordering 0,1,0 with both masters holding WVALID
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b0;
        drv(2'b11, 2'b00, 32'h0000_0000, 32'h1111_0000); #1;
        chk("ord_c0_sready", S_WREADY, 2'b00);
        tick();
        AW_Grant_Id = 1'b1; #1;
        chk("ord_c1_active", Active, 1'b0);
        chk("ord_c1_sready", S_WREADY, 2'b00);
        tick();
        AW_Grant_Id = 1'b0; #1;
        route("ord_c2", 1'b0, 32'h0000_0000, 1'b0);
        chk("ord_c2_strb", M_WSTRB, 4'hF);
        tick();
        AW_Grant_Valid = 1'b0;
        drv(2'b11, 2'b01, 32'h0000_0001, 32'h1111_0000); #1;
        route("ord_c3", 1'b0, 32'h0000_0001, 1'b1);
        tick();
        drv(2'b11, 2'b00, 32'h0000_0010, 32'h1111_0000); #1;
        route("ord_c4", 1'b1, 32'h1111_0000, 1'b0);
        chk("ord_c4_done", Burst_Done, 1'b1);
        chk("ord_c4_done_id", Burst_Done_Id, 1'b0);
        chk("ord_c4_beat", Beat_Count, 8'd0);
        tick();
        drv(2'b11, 2'b10, 32'h0000_0010, 32'h1111_0001); #1;
        route("ord_c5", 1'b1, 32'h1111_0001, 1'b1);
        chk("ord_c5_beat", Beat_Count, 8'd1);
        tick();
        drv(2'b11, 2'b10, 32'h0000_0010, 32'hDEAD_0000); #1;
        route("ord_c6", 1'b0, 32'h0000_0010, 1'b0);
        chk("ord_c6_done", Burst_Done, 1'b1);
        chk("ord_c6_done_id", Burst_Done_Id, 1'b1);
        tick();
        drv(2'b11, 2'b11, 32'h0000_0011, 32'hDEAD_0000); #1;
        route("ord_c7", 1'b0, 32'h0000_0011, 1'b1);
        tick();
        drv(2'b00, 2'b00, 32'h0, 32'h0); #1;
        chk("ord_end_active", Active, 1'b0);
        chk("ord_end_done", Burst_Done, 1'b1);
        chk("ord_end_done_id", Burst_Done_Id, 1'b0);
        chk("ord_end_mvalid", M_WVALID, 1'b0);
        tick();

        // 8-beat burst with M_WREADY alternating 1,0
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b0;
        drv(2'b01, 2'b00, 32'hB000_0000, 32'h0);
        tick();
        AW_Grant_Valid = 1'b0;
        tick();
        for (int j = 0; j < 15; j++) begin
            M_WREADY = ((j % 2) == 0);
            drv(2'b01, {1'b0, ((j / 2) == 7)}, 32'hB000_0000 + 32'(j / 2), 32'h0); #1;
            chk("bp_data", M_WDATA, 32'hB000_0000 + 32'(j / 2));
            chk("bp_sready", S_WREADY, {1'b0, ((j % 2) == 0)});
            chk("bp_beat", Beat_Count, 8'((j + 1) / 2));
            if (M_WVALID && M_WREADY) hs++;
            tick();
        end
        drv(2'b00, 2'b00, 32'h0, 32'h0); M_WREADY = 1'b1; #1;
        chk("bp_beat_end", Beat_Count, 8'd8);
        chk("bp_handshakes", hs, 8);
        chk("bp_done", Burst_Done, 1'b1);
        chk("bp_idle", Active, 1'b0);

        // queue full: four grants while master 1 stalls its burst
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b1;
        tick();
        AW_Grant_Valid = 1'b0;
        tick();
        #1;
        chk("full_active", Active, 1'b1);
        chk("full_active_id", Active_Id, 1'b1);
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b0; tick();
        AW_Grant_Id = 1'b1; tick();
        AW_Grant_Id = 1'b0; tick();
        AW_Grant_Id = 1'b1; tick();
        AW_Grant_Valid = 1'b0; #1;
        chk("full_flag", Queue_Full, 1'b1);
        chk("full_no_ovf", Overflow, 1'b0);
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b1;
        drv(2'b10, 2'b10, 32'h0, 32'hC100_0000); #1;
        chk("full_pop_mvalid", M_WVALID, 1'b1);
        tick();
        AW_Grant_Id = 1'b0;
        drv(2'b00, 2'b00, 32'h0, 32'h0); #1;
        chk("full_pop_flag", Queue_Full, 1'b1);
        chk("full_pop_no_ovf", Overflow, 1'b0);
        chk("full_pop_id", Active_Id, 1'b0);
        chk("full_pop_done", Burst_Done, 1'b1);
        chk("full_pop_done_id", Burst_Done_Id, 1'b1);
        tick();
        AW_Grant_Valid = 1'b0;
        drv(2'b11, 2'b11, 32'h0000_00C0, 32'h0000_00C1); #1;
        chk("ovf_set", Overflow, 1'b1);
        chk("ovf_full", Queue_Full, 1'b1);
        route("drain0", 1'b0, 32'h0000_00C0, 1'b1);
        tick(); #1;
        chk("drain1_full", Queue_Full, 1'b0);
        route("drain1", 1'b1, 32'h0000_00C1, 1'b1);
        tick(); #1;
        route("drain2", 1'b0, 32'h0000_00C0, 1'b1);
        tick(); #1;
        route("drain3", 1'b1, 32'h0000_00C1, 1'b1);
        tick(); #1;
        route("drain4", 1'b1, 32'h0000_00C1, 1'b1);
        tick();
        drv(2'b00, 2'b00, 32'h0, 32'h0); #1;
        chk("drain_idle", Active, 1'b0);
        chk("drain_ovf_sticky", Overflow, 1'b1);
        chk("drain_done_id", Burst_Done_Id, 1'b1);
        tick(); #1;
        chk("dropped_never_served", Active, 1'b0);

        // reset at beat 2 of a 4-beat burst with two IDs queued
        AW_Grant_Valid = 1'b1; AW_Grant_Id = 1'b0;
        drv(2'b01, 2'b00, 32'h0000_00E0, 32'h0);
        tick();
        AW_Grant_Id = 1'b1;
        tick();
        #1;
        route("rstb_b0", 1'b0, 32'h0000_00E0, 1'b0);
        tick();
        AW_Grant_Valid = 1'b0;
        drv(2'b01, 2'b00, 32'h0000_00E1, 32'h0);
        tick();
        drv(2'b01, 2'b00, 32'h0000_00E2, 32'h0); #1;
        chk("rstb_beat2", Beat_Count, 8'd2);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0; #1;
        chk("rstb_active", Active, 1'b0);
        chk("rstb_id", Active_Id, 1'b0);
        chk("rstb_full", Queue_Full, 1'b0);
        chk("rstb_ovf", Overflow, 1'b0);
        chk("rstb_beat", Beat_Count, 8'd0);
        chk("rstb_done", Burst_Done, 1'b0);
        chk("rstb_done_id", Burst_Done_Id, 1'b0);
        chk("rstb_mvalid", M_WVALID, 1'b0);
        chk("rstb_mdata", M_WDATA, 32'h0);
        chk("rstb_mstrb", M_WSTRB, 4'h0);
        chk("rstb_mlast", M_WLAST, 1'b0);
        chk("rstb_sready", S_WREADY, 2'b00);
        tick(); #1;
        chk("rstb_queue_empty", Active, 1'b0);
        chk("rstb_no_done", Burst_Done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
